// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - regfile write-port arbiter: pipeline writeback vs queued long-unit results
// Optional statistics counters are built when WB_ARB_STATS_EN is defined.
module regfile_wb_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int LU_DEPTH   = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [DATA_W-1:0] lu_wdata,
    input  logic              re1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              stall_req,
`ifdef WB_ARB_STATS_EN
    output logic [15:0]       stat_squash,
    output logic [15:0]       stat_stall,
`endif
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int PTR_W = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
    localparam int CNT_W = $clog2(LU_DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0]   q_addr_q [LU_DEPTH];
    logic [DATA_W-1:0]   q_data_q [LU_DEPTH];
    logic [LU_DEPTH-1:0] q_valid_q, q_valid_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ST_W-1:0]     starve_q, starve_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

    logic wb_claim, q_empty, q_full, pop, head_valid, lu_drop, enq, raw, starved;

    assign wb_claim   = wb_we && (wb_waddr != '0);
    assign q_empty    = (count_q == '0);
    assign q_full     = (count_q == CNT_W'(LU_DEPTH));
    assign lu_ready   = !q_full;
    assign pop        = !wb_claim && !q_empty;
    assign head_valid = !q_empty && q_valid_q[head_q];
    // A long-unit write colliding with a same-cycle pipeline write is older, so it is dropped
    assign lu_drop    = lu_valid && lu_ready && (lu_waddr != '0) && wb_claim && (wb_waddr == lu_waddr);
    assign enq        = lu_valid && lu_ready && (lu_waddr != '0) && !lu_drop;
    assign starved    = (starve_q == ST_W'(STARVE_MAX));
    assign stall_req  = raw || starved;

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < LU_DEPTH; i++) begin
            if (q_valid_q[i] && re1 && (raddr1 != '0) && (q_addr_q[i] == raddr1))
                raw = 1'b1;
            if (q_valid_q[i] && re2 && (raddr2 != '0) && (q_addr_q[i] == raddr2))
                raw = 1'b1;
        end
    end

    always_comb begin
        q_valid_d = q_valid_q;
        if (pop)
            q_valid_d[head_q] = 1'b0;
        if (wb_claim) begin
            for (int i = 0; i < LU_DEPTH; i++) begin
                if (q_valid_q[i] && (q_addr_q[i] == wb_waddr))
                    q_valid_d[i] = 1'b0;
            end
        end
        if (enq)
            q_valid_d[tail_q] = 1'b1;

        head_d  = pop ? head_q + PTR_W'(1) : head_q;
        tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);

        if (pop || q_empty)
            starve_d = '0;
        else if (head_valid && !starved)
            starve_d = starve_q + ST_W'(1);
        else
            starve_d = starve_q;

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_claim) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wb_waddr;
            rf_wdata_d = wb_wdata;
        end else if (pop && q_valid_q[head_q]) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = q_addr_q[head_q];
            rf_wdata_d = q_data_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            q_valid_q  <= q_valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Payload storage needs no reset: entries are only read while their valid bit is set
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr_q[tail_q] <= lu_waddr;
            q_data_q[tail_q] <= lu_wdata;
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [CNT_W-1:0] squash_cnt;
    logic [16:0]      squash_sum;
    logic [15:0]      stat_squash_q, stat_squash_d, stat_stall_q, stat_stall_d;

    always_comb begin
        squash_cnt = '0;
        if (wb_claim) begin
            for (int i = 0; i < LU_DEPTH; i++) begin
                if (q_valid_q[i] && (q_addr_q[i] == wb_waddr))
                    squash_cnt = squash_cnt + CNT_W'(1);
            end
        end
        squash_sum    = 17'(stat_squash_q) + 17'(squash_cnt) + 17'(lu_drop);
        stat_squash_d = (squash_sum > 17'h0FFFF) ? 16'hFFFF : squash_sum[15:0];
        stat_stall_d  = (stall_req && (stat_stall_q != 16'hFFFF)) ? stat_stall_q + 16'd1 : stat_stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_squash_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_squash_q <= stat_squash_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_squash = stat_squash_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback and a long-latency unit (multiply/divide) that returns results out of band. The pipeline always wins the port. Long-unit results wait in a small in-order queue and drain on idle write cycles. The block squashes stale queued writes (WAW), flags RAW hazards on queued destinations, and forces a pipeline stall when a queued result has waited too long. It sits between MEM/WB, the long-latency unit and the regfile write port.

Parameters:
ADDR_W, 5, register address width (register 0 hard-wired zero)
DATA_W, 32, data width
LU_DEPTH, 2, long-unit queue entries (power of 2, >=2)
STARVE_MAX, 8, cycles the queue head may wait before a forced stall

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
wb_we  in  1  pipeline writeback enable; no backpressure, always accepted
wb_waddr  in  ADDR_W  pipeline destination
wb_wdata  in  DATA_W  pipeline data
lu_valid  in  1  long-unit result valid
lu_ready  out  1  queue can accept; equals !full, from registered state only
lu_waddr  in  ADDR_W  long-unit destination
lu_wdata  in  DATA_W  long-unit data
re1, re2  in  1 each  read enables of the decode read ports
raddr1, raddr2  in  ADDR_W each  read addresses of the decode read ports
stall_req  out  1  pipeline stall request (combinational)
rf_we  out  1  registered regfile write enable
rf_waddr  out  ADDR_W  registered regfile write address
rf_wdata  out  DATA_W  registered regfile write data

Behaviour:
- Reset (rst=0, any time, asynchronous): queue empty, all entry valid bits 0, starve counter 0, rf_we=0, rf_waddr=0, rf_wdata=0. Reset mid-drain discards queued writes.
- Write-port selection each rising edge, in priority order:
  - wb_we=1 and wb_waddr!=0: rf_* <= pipeline write (latency 1).
  - Otherwise, queue non-empty: pop the head. If the head is valid, rf_* <= head write; if it was squashed, rf_we <= 0.
  - Otherwise: rf_we <= 0. rf_waddr and rf_wdata hold their previous values.
- Writes to address 0 from either source are discarded.
  - The pipeline path does not claim the port, so a queue pop may happen that cycle.
  - A long-unit handshake to address 0 completes but nothing is enqueued.
- Enqueue: lu_valid=1 and lu_ready=1 and lu_waddr!=0 writes the tail entry, valid=1.
  - A new entry is not poppable in its enqueue cycle; minimum long-unit latency to rf_we is 2 cycles.
  - Enqueue and pop in the same cycle are legal when not full.
- Squash (WAW): when wb_we=1 and wb_waddr!=0, every queued entry with a matching address has its valid bit cleared.
  - A long-unit write arriving the same cycle to the same address is older and is not enqueued; the handshake still completes.
- RAW hazard: stall_req=1 if (re1 and raddr1!=0 and raddr1 matches a valid queued entry) or the same condition holds for port 2.
- Starvation:
  - The counter increments each cycle the head is valid and not popped.
  - It clears on pop or when the queue is empty, and saturates at STARVE_MAX.
  - At STARVE_MAX, stall_req=1 until the head pops.
  - The pipeline deasserts wb_we on the cycle after stall_req, which guarantees the drain.
- Order: queued writes retire strictly FIFO; pointers wrap modulo LU_DEPTH, with a separate count giving full/empty.
- lu_ready=0 when full, even if a pop occurs that cycle; there is no same-cycle full bypass.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_squash (16-bit, counts squashed queue entries plus dropped same-cycle long-unit writes) and stat_stall (16-bit, counts cycles with stall_req=1).
  - Both are saturating at 16'hFFFF and cleared by reset.
- Undefined: these ports and counters are absent. Core behaviour is identical either way.

Test Plan:
- Reset release, then wb_we=1, wb_waddr=5, wb_wdata=32'hA5A5_0001 -> next edge rf_we=1, rf_waddr=5, rf_wdata=32'hA5A5_0001; lu_ready=1.
- Long-unit write reg 7 = 32'h1234 with wb_we=0 -> rf_we=1, rf_waddr=7 two edges after the handshake; in the cycle between, re1=1, raddr1=7 gives stall_req=1.
- Queue reg 9 then reg 10 during continuous pipeline writes (LU_DEPTH=2) -> lu_ready=0. After 8 waiting cycles stall_req=1. With wb_we=0, regs 9 then 10 retire on consecutive edges.
- Queue reg 3 = 32'h1, then pipeline writes reg 3 = 32'h2 -> rf writes only 32'h2. The squashed pop yields rf_we=0. stat_squash=1 with WB_ARB_STATS_EN.
- Same-cycle long-unit and pipeline writes to reg 4 -> only the pipeline value is written; the queue stays empty.
- Reset asserted with 2 queued entries -> rf_we=0 immediately; after release, no queued write appears and lu_ready=1.
